fifo_mem_ctrl: RTL and testbench
================================

// Module: fifo_mem_ctrl
// PURPOSE
//  Sequencing controller for the parameterised single-clock storage array: turns raw wr_addr/rd_addr
//  access into a FIFO with push/pop requests, full/empty status, occupancy count and error flags.
//  Owns the write/read pointers and the storage instance; sits between a producer and a consumer
//  so neither drives memory addresses directly.
// PARAMETERS
//  DW        6    data width, bits
//  DEPTH     32   entries; power of 2, >= 2
//  AW        5    address width, = log2(DEPTH)
//  AF_LEVEL  28   almost_full asserts when count >= AF_LEVEL; 1..DEPTH
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  wr_en        in   1      push request
//  data_in      in   DW     push data, sampled with wr_en
//  rd_en        in   1      pop request
//  data_out     out  DW     popped data, registered
//  rd_valid     out  1      data_out carries a newly popped word this cycle
//  full         out  1      count == DEPTH
//  almost_full  out  1      count >= AF_LEVEL
//  empty        out  1      count == 0
//  count        out  AW+1   current occupancy, 0..DEPTH
//  overflow     out  1      1-cycle pulse: wr_en while full (push dropped)
//  underflow    out  1      1-cycle pulse: rd_en while empty (pop ignored)
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, data_out=0,
//    rd_valid=0, overflow=underflow=0. Storage contents not reset, undefined after reset.
//  - Reset mid-operation: all state cleared immediately, queued words discarded, an in-flight pop
//    produces no rd_valid.
//  - Pointers AW+1 bits; address = ptr[AW-1:0]; wrap DEPTH-1 -> 0 with MSB toggle.
//    full = (addr bits equal, MSBs differ); empty = (ptrs equal). Flags/count registered, from pointers.
//  - push accepted = wr_en & !full (full as of current cycle): mem[wr_ptr] <= data_in, wr_ptr+1.
//  - pop accepted  = rd_en & !empty: data_out <= mem[rd_ptr] at that edge, rd_ptr+1, rd_valid=1 next cycle.
//    Read latency 1 clock, request to data. No fall-through: a word pushed in cycle N is poppable from N+1.
//  - rd_valid high exactly one cycle per accepted pop; data_out holds last popped value otherwise.
//  - Simultaneous push+pop: both evaluated against current flags.
//    empty: push accepted, pop rejected + underflow. full: pop accepted, push rejected + overflow.
//    Otherwise both accepted, count unchanged.
//  - count: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH or goes negative.
//  - Rejected requests change no pointer, count or storage state.
// STRUCTURE
//  - Shared package fifo_pkg: default DW/DEPTH/AF_LEVEL constants, clog2 function for AW.
//  - One sub-module: fifo_mem_ram (DW x DEPTH array; write port wr_en/wr_addr/data_in,
//    registered read port rd_en/rd_addr/data_out, no reset on array).
//  - Pointer/flag/count logic and error pulses in this module.
// TESTING
//  - Reset, then 32 pushes 0x00..0x1F: full=1 after 32nd edge, count=32, almost_full from count=28.
//  - 33rd push 0x3F while full: overflow pulses 1 cycle, count stays 32, no storage change.
//  - 32 pops: data_out 0x00..0x1F in order, rd_valid 1 cycle after each rd_en, empty=1 at end.
//  - pop while empty: underflow pulses, rd_valid stays 0, data_out holds 0x1F.
//  - Push+pop same cycle at full: pop yields oldest word, push dropped with overflow, count 32->31.
//  - 40 interleaved push/pop with pointer wrap; then rst_n low mid-pop: rd_valid 0, count 0, empty 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO storage controller.
// Default geometry plus a clog2 used to size address fields.
package fifo_pkg;

  localparam int FIFO_DW    = 6;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_AF    = 28;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// Single-clock DW x DEPTH storage array.
// Write port plus registered read port; array itself is not reset.
module fifo_mem_ram
  import fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] data_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] mem [DEPTH];

  // array write, no reset so it maps onto plain storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  // read register holds the last popped word between pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_out <= '0;
    else if (rd_en) data_out <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// FIFO sequencing around fifo_mem_ram: pointers, flags,
// occupancy and one-cycle overflow/underflow pulses.
module fifo_mem_ctrl
  import fifo_pkg::*;
#(
  parameter int DW       = FIFO_DW,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int AF_LEVEL = FIFO_AF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] data_in,
  input  logic          rd_en,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_nxt, rd_nxt, cnt_nxt;
  logic        push_ok, pop_ok;

  // both requests judged against this cycle's registered flags
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);
  assign cnt_nxt = wr_nxt - rd_nxt;

  fifo_mem_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push_ok),
    .wr_addr  (wr_ptr[AW-1:0]),
    .data_in  (data_in),
    .rd_en    (pop_ok),
    .rd_addr  (rd_ptr[AW-1:0]),
    .data_out (data_out)
  );

  // pointers and status flags, flags derived from next pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      count       <= cnt_nxt;
      empty       <= (wr_nxt == rd_nxt);
      full        <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0])
                  && (wr_nxt[AW] != rd_nxt[AW]);
      almost_full <= (cnt_nxt >= (AW+1)'(AF_LEVEL));
    end
  end

  // pop strobe and error pulses, each lasting one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= pop_ok;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl: fill, overflow, drain,
// underflow, full/empty collisions, wrap and async reset.
module tb_fifo_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [5:0] data_out;
  logic       rd_valid, full, almost_full, empty;
  logic [5:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [5:0] q[$];
  logic [5:0] exp_d;

  always #5 clk = ~clk;

  fifo_mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // fill with 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      data_in = 6'(i);
      step();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 28) ? 1 : 0);
      chk("fill_full", full, (i == 31) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end

    // push while full
    data_in = 6'h3F;
    step();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 32);
    chk("ovf_full", full, 1);
    wr_en = 1'b0;
    step();
    chk("ovf_clear", overflow, 0);

    // drain in order
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      step();
      chk("pop_valid", rd_valid, 1);
      chk("pop_data", data_out, i);
      chk("pop_count", count, 31 - i);
    end
    rd_en = 1'b0;
    step();
    chk("drain_valid", rd_valid, 0);
    chk("drain_empty", empty, 1);
    chk("drain_af", almost_full, 0);

    // pop while empty
    rd_en = 1'b1;
    step();
    chk("unf_pulse", underflow, 1);
    chk("unf_valid", rd_valid, 0);
    chk("unf_dout", data_out, 6'h1F);
    chk("unf_count", count, 0);
    rd_en = 1'b0;
    step();
    chk("unf_clear", underflow, 0);

    // push+pop while empty: push only
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 6'h11;
    step();
    chk("pe_unf", underflow, 1);
    chk("pe_valid", rd_valid, 0);
    chk("pe_count", count, 1);
    wr_en = 1'b0;
    step();
    chk("pe_pop_valid", rd_valid, 1);
    chk("pe_pop_data", data_out, 6'h11);
    chk("pe_empty", empty, 1);
    rd_en = 1'b0;

    // refill with 0x20..0x3F
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      data_in = 6'(32 + i);
      q.push_back(6'(32 + i));
      step();
    end
    chk("refill_full", full, 1);

    // push+pop while full: pop only
    rd_en = 1'b1;
    data_in = 6'h05;
    exp_d = q.pop_front();
    step();
    chk("pf_valid", rd_valid, 1);
    chk("pf_data", data_out, exp_d);
    chk("pf_ovf", overflow, 1);
    chk("pf_count", count, 31);
    chk("pf_full", full, 0);

    // 40 simultaneous push/pop, pointers wrap
    for (int i = 0; i < 40; i++) begin
      data_in = 6'(i);
      exp_d = q.pop_front();
      q.push_back(6'(i));
      step();
      chk("wrap_valid", rd_valid, 1);
      chk("wrap_data", data_out, exp_d);
      chk("wrap_count", count, 31);
    end
    wr_en = 1'b0;

    // async reset in the middle of a pop
    rd_en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", rd_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    step();
    chk("mrst_hold_valid", rd_valid, 0);
    chk("mrst_hold_count", count, 0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_empty", empty, 1);
    chk("post_valid", rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
